// File: rtl/reed_solomon_decoder_frame_scheduler_if.sv
// Handshake bundle between the RS decoder input FIFO, the decoder core
// and the frame scheduler.
// Signals:
//   fifo_count/fifo_not_empty/fifo_deq_en : FIFO dequeue side
//   dec_start/dec_valid/dec_last/dec_ready/dec_done : decoder side
//   flush/busy/frames_issued : control and status
// master = scheduler side, slave = FIFO/decoder/software side.
interface reed_solomon_decoder_frame_scheduler_if #(
    parameter int CNT_W = 10
);
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_not_empty;
    logic             fifo_deq_en;
    logic             dec_start;
    logic             dec_valid;
    logic             dec_last;
    logic             dec_ready;
    logic             dec_done;
    logic             flush;
    logic             busy;
    logic [31:0]      frames_issued;

    modport master (
        input  fifo_count, fifo_not_empty, dec_ready, dec_done, flush,
        output fifo_deq_en, dec_start, dec_valid, dec_last,
        output busy, frames_issued
    );

    modport slave (
        output fifo_count, fifo_not_empty, dec_ready, dec_done, flush,
        input  fifo_deq_en, dec_start, dec_valid, dec_last,
        input  busy, frames_issued
    );
endinterface

// File: rtl/reed_solomon_decoder_frame_scheduler.sv
// Frame scheduler: waits for a full codeword in the FIFO, pulses dec_start,
// streams FRAME_BEATS beats under valid/ready, then waits for dec_done.
// Also drains the FIFO on a flush request taken in IDLE.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : master side of reed_solomon_decoder_frame_scheduler_if
module reed_solomon_decoder_frame_scheduler #(
    parameter int FRAME_BEATS = 4,
    parameter int FIFO_DEPTH  = 512,
    parameter int CNT_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic clk,
    input  logic reset,
    reed_solomon_decoder_frame_scheduler_if.master bus
);
    localparam int BW = $clog2(FRAME_BEATS + 1);
    localparam logic [BW-1:0]    LAST_BEAT = BW'(FRAME_BEATS - 1);
    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_BEATS);

    typedef enum logic [2:0] {
        IDLE,
        START,
        STREAM,
        WAIT_DONE,
        FLUSH
    } state_e;

    state_e      state_q, state_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [31:0] frames_q, frames_d;

    logic valid_c;
    logic last_c;
    logic deq_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            frames_q <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            frames_q <= frames_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        frames_d = frames_q;
        valid_c  = 1'b0;
        last_c   = 1'b0;
        deq_c    = 1'b0;
        unique case (state_q)
            IDLE: begin
                // flush wins over a frame that is ready the same cycle
                if (bus.flush) begin
                    state_d = FLUSH;
                end else if (bus.fifo_count >= FRAME_CNT) begin
                    state_d = START;
                end
            end
            START: begin
                beat_d  = '0;
                state_d = STREAM;
            end
            STREAM: begin
                // underrun just stalls: valid follows the FIFO head
                valid_c = bus.fifo_not_empty;
                last_c  = valid_c && (beat_q == LAST_BEAT);
                deq_c   = valid_c && bus.dec_ready;
                if (deq_c) begin
                    beat_d = beat_q + BW'(1);
                    if (last_c) begin
                        state_d = WAIT_DONE;
                    end
                end
            end
            WAIT_DONE: begin
                if (bus.dec_done) begin
                    frames_d = frames_q + 32'd1;
                    state_d  = IDLE;
                end
            end
            FLUSH: begin
                deq_c = bus.fifo_not_empty;
                if (!bus.fifo_not_empty) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.dec_start     = (state_q == START);
    assign bus.busy          = (state_q != IDLE);
    assign bus.frames_issued = frames_q;
    assign bus.dec_valid     = valid_c;
    assign bus.dec_last      = last_c;
    assign bus.fifo_deq_en   = deq_c;
endmodule

// File: tb/tb_reed_solomon_decoder_frame_scheduler.sv
// Directed bench for the RS decoder frame scheduler (FRAME_BEATS=4).
// Cycle-by-cycle vector table plus sequences for reset, done drop and wrap.
module tb_reed_solomon_decoder_frame_scheduler;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    reed_solomon_decoder_frame_scheduler_if #(.CNT_W(10)) bus ();

    reed_solomon_decoder_frame_scheduler #(
        .FRAME_BEATS(4),
        .FIFO_DEPTH (512),
        .CNT_W      (10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic        rst;
        logic [9:0]  cnt;
        logic        ne;
        logic        rdy;
        logic        done;
        logic        fl;
        logic        st;
        logic        va;
        logic        la;
        logic        dq;
        logic        bz;
        logic [31:0] fr;
    } vec_t;

    vec_t vq[$];
    int errors = 0;
    int checks = 0;

    task automatic add(input logic rst, input int cnt, input logic ne,
                       input logic rdy, input logic done, input logic fl,
                       input logic st, input logic va, input logic la,
                       input logic dq, input logic bz, input int fr);
        vec_t v;
        v.rst = rst; v.cnt = 10'(cnt); v.ne = ne; v.rdy = rdy;
        v.done = done; v.fl = fl; v.st = st; v.va = va; v.la = la;
        v.dq = dq; v.bz = bz; v.fr = 32'(fr);
        vq.push_back(v);
    endtask

    task automatic drive(input logic r, input int c, input logic ne,
                         input logic rdy, input logic dn, input logic fl);
        @(negedge clk);
        reset              = r;
        bus.fifo_count     = 10'(c);
        bus.fifo_not_empty = ne;
        bus.dec_ready      = rdy;
        bus.dec_done       = dn;
        bus.flush          = fl;
        #1;
    endtask

    task automatic expect_out(input string nm, input logic st,
                              input logic va, input logic la,
                              input logic dq, input logic bz,
                              input logic [31:0] fr);
        checks++;
        if ({bus.dec_start, bus.dec_valid, bus.dec_last,
             bus.fifo_deq_en, bus.busy, bus.frames_issued}
            !== {st, va, la, dq, bz, fr}) begin
            errors++;
            $display("FAIL %s: got start=%b valid=%b last=%b deq=%b busy=%b frames=%h want start=%b valid=%b last=%b deq=%b busy=%b frames=%h",
                     nm, bus.dec_start, bus.dec_valid, bus.dec_last,
                     bus.fifo_deq_en, bus.busy, bus.frames_issued,
                     st, va, la, dq, bz, fr);
        end
    endtask

    initial begin
        bit found;

        // threshold not met, stray done in IDLE
        add(0, 3, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0);
        add(0, 3, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0);
        add(0, 3, 1, 1, 1, 0,  0, 0, 0, 0, 0, 0);
        // single frame, ready held high, stray done in STREAM
        add(0, 4, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0);
        add(0, 4, 1, 1, 0, 0,  1, 0, 0, 0, 1, 0);
        add(0, 4, 1, 1, 0, 0,  0, 1, 0, 1, 1, 0);
        add(0, 4, 1, 1, 1, 0,  0, 1, 0, 1, 1, 0);
        add(0, 4, 1, 1, 0, 0,  0, 1, 0, 1, 1, 0);
        add(0, 4, 1, 1, 0, 0,  0, 1, 1, 1, 1, 0);
        add(0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 1, 1, 0,  0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 1);
        // back-pressure: ready 1,0,0,1,1,0,1
        add(0, 4, 1, 0, 0, 0,  0, 0, 0, 0, 0, 1);
        add(0, 4, 1, 1, 0, 0,  1, 0, 0, 0, 1, 1);
        add(0, 4, 1, 1, 0, 0,  0, 1, 0, 1, 1, 1);
        add(0, 4, 1, 0, 0, 0,  0, 1, 0, 0, 1, 1);
        add(0, 4, 1, 0, 0, 0,  0, 1, 0, 0, 1, 1);
        add(0, 4, 1, 1, 0, 0,  0, 1, 0, 1, 1, 1);
        add(0, 4, 1, 1, 0, 0,  0, 1, 0, 1, 1, 1);
        add(0, 4, 1, 0, 0, 0,  0, 1, 1, 0, 1, 1);
        add(0, 4, 1, 1, 0, 0,  0, 1, 1, 1, 1, 1);
        add(0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 1, 1);
        add(0, 0, 0, 1, 1, 0,  0, 0, 0, 0, 1, 1);
        add(0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 2);
        // underrun mid-frame
        add(0, 4, 1, 1, 0, 0,  0, 0, 0, 0, 0, 2);
        add(0, 4, 1, 1, 0, 0,  1, 0, 0, 0, 1, 2);
        add(0, 4, 1, 1, 0, 0,  0, 1, 0, 1, 1, 2);
        add(0, 4, 0, 1, 0, 0,  0, 0, 0, 0, 1, 2);
        add(0, 4, 0, 1, 0, 0,  0, 0, 0, 0, 1, 2);
        add(0, 4, 1, 1, 0, 0,  0, 1, 0, 1, 1, 2);
        add(0, 4, 1, 1, 0, 0,  0, 1, 0, 1, 1, 2);
        add(0, 4, 1, 1, 0, 0,  0, 1, 1, 1, 1, 2);
        add(0, 0, 0, 1, 1, 0,  0, 0, 0, 0, 1, 2);
        add(0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 3);
        // flush beats a ready frame, 7 dequeues, no frame counted
        add(0, 7, 1, 1, 0, 1,  0, 0, 0, 0, 0, 3);
        for (int i = 0; i < 7; i++) begin
            add(0, 6 - i, 1, 0, 0, 0,  0, 0, 0, 1, 1, 3);
        end
        add(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 3);
        add(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 3);

        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        foreach (vq[i]) begin
            drive(vq[i].rst, int'(vq[i].cnt), vq[i].ne, vq[i].rdy,
                  vq[i].done, vq[i].fl);
            expect_out($sformatf("vec%0d", i), vq[i].st, vq[i].va,
                       vq[i].la, vq[i].dq, vq[i].bz, vq[i].fr);
        end

        // done coinciding with the last transfer is dropped
        drive(0, 4, 1, 1, 0, 0); expect_out("dl_idle", 0, 0, 0, 0, 0, 3);
        drive(0, 4, 1, 1, 0, 0); expect_out("dl_start", 1, 0, 0, 0, 1, 3);
        drive(0, 4, 1, 1, 0, 0); expect_out("dl_b0", 0, 1, 0, 1, 1, 3);
        drive(0, 4, 1, 1, 0, 0); expect_out("dl_b1", 0, 1, 0, 1, 1, 3);
        drive(0, 4, 1, 1, 0, 0); expect_out("dl_b2", 0, 1, 0, 1, 1, 3);
        drive(0, 4, 1, 1, 1, 0); expect_out("dl_b3", 0, 1, 1, 1, 1, 3);
        drive(0, 0, 0, 0, 0, 0); expect_out("dl_wait", 0, 0, 0, 0, 1, 3);
        drive(0, 0, 0, 0, 1, 0); expect_out("dl_done", 0, 0, 0, 0, 1, 3);
        // minimum gap: done, IDLE, START
        drive(0, 4, 1, 1, 0, 0); expect_out("gap_idle", 0, 0, 0, 0, 0, 4);
        drive(0, 4, 1, 1, 0, 0); expect_out("gap_start", 1, 0, 0, 0, 1, 4);

        // reset held 2 cycles mid-STREAM
        drive(0, 4, 1, 1, 0, 0); expect_out("rs_b0", 0, 1, 0, 1, 1, 4);
        drive(0, 4, 1, 1, 0, 0); expect_out("rs_b1", 0, 1, 0, 1, 1, 4);
        drive(1, 4, 1, 1, 0, 0);
        drive(1, 4, 1, 1, 0, 0); expect_out("rs_hold", 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 1, 0, 0); expect_out("rs_after", 0, 0, 0, 0, 0, 0);

        // frames_issued wrap
        @(negedge clk);
        force dut.frames_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.frames_q;
        drive(0, 0, 0, 0, 0, 0);
        expect_out("wr_pre", 0, 0, 0, 0, 0, 32'hFFFF_FFFF);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            drive(0, 4, 1, 1, 0, 0);
            found = bus.dec_start;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wr_start_wait: got no dec_start in 8 cycles, want dec_start");
        end
        drive(0, 4, 1, 1, 0, 0); expect_out("wr_b0", 0, 1, 0, 1, 1, 32'hFFFF_FFFF);
        drive(0, 4, 1, 1, 0, 0); expect_out("wr_b1", 0, 1, 0, 1, 1, 32'hFFFF_FFFF);
        drive(0, 4, 1, 1, 0, 0); expect_out("wr_b2", 0, 1, 0, 1, 1, 32'hFFFF_FFFF);
        drive(0, 4, 1, 1, 0, 0); expect_out("wr_b3", 0, 1, 1, 1, 1, 32'hFFFF_FFFF);
        drive(0, 0, 0, 0, 1, 0); expect_out("wr_done", 0, 0, 0, 0, 1, 32'hFFFF_FFFF);
        drive(0, 0, 0, 0, 0, 0); expect_out("wr_zero", 0, 0, 0, 0, 0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/reed_solomon_decoder_frame_scheduler.md
# reed_solomon_decoder_frame_scheduler

Sequences the 512-bit RS decoder input FIFO into the decoder core one codeword at a time. It waits until a complete frame (FRAME_BEATS beats) is buffered, then raises a start pulse and drains exactly that many beats under a valid/ready handshake. It holds off the next frame until the decoder reports completion, and also provides a software-triggered FIFO flush. It sits between the FIFO's dequeue side and the decoder core; beat data passes directly from the FIFO to the decoder and does not go through this block.

## Interface
- FRAME_BEATS, default 4: 512-bit beats per codeword; legal range 1..FIFO_DEPTH-1.
- FIFO_DEPTH, default 512: depth of the controlled FIFO.
- CNT_W, default $clog2(FIFO_DEPTH)+1: width of the occupancy input.

- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- fifo_count  in  CNT_W  FIFO occupancy in beats (zero-extended/truncated by integrator).
- fifo_not_empty  in  1  FIFO holds at least one beat.
- fifo_deq_en  out  1  dequeue strobe to FIFO.
- dec_start  out  1  one-cycle pulse marking start of a frame.
- dec_valid  out  1  current FIFO head beat is valid for the decoder.
- dec_last  out  1  qualifies the final beat of a frame.
- dec_ready  in  1  decoder accepts a beat this cycle.
- dec_done  in  1  decoder finished the current frame (single-cycle pulse).
- flush  in  1  request to discard all FIFO contents.
- busy  out  1  state is not IDLE.
- frames_issued  out  32  count of completed frames; wraps modulo 2^32.

## Operation
- FSM states: IDLE, START, STREAM, WAIT_DONE, FLUSH. Encoding is free.
- The state register, beat counter (width $clog2(FRAME_BEATS+1)) and frames_issued reset to IDLE, 0 and 0.
- **IDLE**
  - flush=1 → FLUSH. flush has priority over frame start.
  - Otherwise, fifo_count >= FRAME_BEATS → START.
  - Otherwise, stay in IDLE.
- **START**
  - dec_start=1 for exactly this cycle.
  - Clear the beat counter.
  - Unconditionally go to STREAM.
- **STREAM**
  - dec_valid = fifo_not_empty.
  - fifo_deq_en = dec_valid & dec_ready.
  - The beat counter increments on each transfer.
  - dec_last = dec_valid & (beat counter == FRAME_BEATS-1).
  - A transfer with dec_last → WAIT_DONE.
- **WAIT_DONE**
  - No dequeues.
  - dec_done=1 → IDLE and frames_issued += 1.
- **FLUSH**
  - fifo_deq_en = fifo_not_empty.
  - fifo_not_empty=0 → IDLE.
  - Beats dequeued here are never counted as frames.
- Outside their states, dec_valid, dec_last, fifo_deq_en and dec_start are 0.
- busy = (state != IDLE).
- flush is sampled only in IDLE; a flush asserted elsewhere is ignored and must be held by the requester.
- dec_done is sampled only in WAIT_DONE; a pulse in any other state, including the cycle of the last transfer, is dropped.

## Timing
- dec_start, busy and frames_issued are decoded from registers and carry no combinational path from inputs.
- dec_valid, dec_last and fifo_deq_en are combinational from the state plus fifo_not_empty and dec_ready, giving a same-cycle handshake.
- Frame-start latency:
  - fifo_count reaches FRAME_BEATS in cycle t.
  - START (dec_start=1) occurs in cycle t+1.
  - The first beat can transfer in cycle t+2.
- With dec_ready held at 1, STREAM lasts exactly FRAME_BEATS cycles.
- dec_ready=0 stalls without losing a beat; the counter and dec_last hold.
- fifo_not_empty=0 in STREAM (underrun) holds dec_valid at 0 and stalls the frame; no error is raised.
- FRAME_BEATS=1: STREAM transfers one beat with dec_last=1 on it.
- Earliest next frame: cycle after dec_done → IDLE, next cycle START. Minimum gap is 2 cycles from dec_done to the next dec_start.
- reset asserted in any state:
  - At the next edge, return to IDLE and clear the counters.
  - All strobes are 0 in the reset cycle's outputs.
  - A partially streamed frame is abandoned.
- frames_issued at 0xFFFF_FFFF plus dec_done → 0x0000_0000.

## Test plan
- **Reset:** assert reset 2 cycles mid-STREAM → state IDLE, busy=0, frames_issued=0, fifo_deq_en=0 next cycle.
- **Single frame:** FRAME_BEATS=4, fifo_count=4, dec_ready=1 → dec_start at t+1 and 4 consecutive fifo_deq_en. dec_last is on beat 4 only. busy is held until dec_done; then frames_issued=1.
- **Back-pressure:** dec_ready toggles 1,0,0,1,1,0,1 → exactly 4 dequeues, on ready-high cycles only, with dec_last on the 4th transfer.
- **Threshold/stall:** fifo_count=3 → no dec_start indefinitely. Raise it to 4 → dec_start the next cycle. Drop fifo_not_empty mid-frame → dec_valid=0 until it returns.
- **Flush:** in IDLE with fifo_count=7 and flush=1 (same cycle as count >= FRAME_BEATS) → FLUSH wins and 7 dequeue cycles follow. frames_issued is unchanged; back to IDLE when empty.
- **Stray done/wrap:** dec_done pulsed in IDLE and STREAM → ignored. Preload frames_issued to 0xFFFF_FFFF via a force, complete a frame → 0.
